// File: rtl/int_ctrl.sv
// Interrupt sequencer: latches IRQ rising edges, freezes the pipeline, redirects to the
// handler vector, and on mret replays the same pause/redirect back to the saved epc.
module int_ctrl #(
   parameter int unsigned NUM_IRQ      = 4,
   parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
   parameter int unsigned PAUSE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               int_en,
   input  logic               mret,
   input  logic [31:0]        resume_pc,
   output logic               int_set_pl_pause,
   output logic               int_flag,
   output logic [31:0]        int_pc,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [3:0]         int_cause,
   output logic [31:0]        epc,
   output logic               in_isr
);
   localparam int unsigned      CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAUSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PAUSE  = 3'd1,
      ST_ENTER  = 3'd2,
      ST_ISR    = 3'd3,
      ST_RPAUSE = 3'd4,
      ST_RETURN = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         cause_q, cause_d;
   logic [31:0]        epc_q, epc_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic               pause_q, pause_d;
   logic               flag_q, flag_d;
   logic               in_isr_q, in_isr_d;
   logic [31:0]        pc_q, pc_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;

   // Lowest set index wins, so scan from the top and let lower hits overwrite.
   function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] vec);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         idx = vec[i] ? 4'(i) : idx;
      end
      return idx;
   endfunction

   // Next-state, pending bookkeeping and output decode from the upcoming state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      pending_d = (pending_q & ~ack_q) | (irq & ~irq_q);
      case (state_q)
         ST_IDLE: begin
            if (int_en && (|pending_q)) begin
               cause_d = lowest_idx(pending_q);
               cnt_d   = CNT_LOAD;
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PAUSE: begin
            if (cnt_q == CNT_ZERO) begin
               epc_d   = resume_pc;
               state_d = ST_ENTER;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ENTER: begin
            state_d = ST_ISR;
         end
         ST_ISR: begin
            if (mret) begin
               cnt_d   = CNT_LOAD;
               state_d = ST_RPAUSE;
            end else begin
               state_d = ST_ISR;
            end
         end
         ST_RPAUSE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_RETURN;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RETURN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from state_d so they line up with the state they describe.
      pause_d  = (state_d == ST_PAUSE) || (state_d == ST_RPAUSE);
      flag_d   = (state_d == ST_ENTER) || (state_d == ST_RETURN);
      in_isr_d = (state_d == ST_ISR) || (state_d == ST_RPAUSE);
      case (state_d)
         ST_ENTER:  pc_d = VEC_BASE + {26'd0, cause_d, 2'b00};
         ST_RETURN: pc_d = epc_d;
         default:   pc_d = 32'd0;
      endcase
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_d[i] = (state_d == ST_ENTER) && (cause_d == 4'(i));
      end
   end

   // State, bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         cause_q   <= 4'd0;
         epc_q     <= 32'd0;
         pending_q <= {NUM_IRQ{1'b0}};
         irq_q     <= {NUM_IRQ{1'b0}};
         pause_q   <= 1'b0;
         flag_q    <= 1'b0;
         in_isr_q  <= 1'b0;
         pc_q      <= 32'd0;
         ack_q     <= {NUM_IRQ{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         pending_q <= pending_d;
         irq_q     <= irq;
         pause_q   <= pause_d;
         flag_q    <= flag_d;
         in_isr_q  <= in_isr_d;
         pc_q      <= pc_d;
         ack_q     <= ack_d;
      end
   end

   assign int_set_pl_pause = pause_q;
   assign int_flag         = flag_q;
   assign int_pc           = pc_q;
   assign irq_ack          = ack_q;
   assign int_cause        = cause_q;
   assign epc              = epc_q;
   assign in_isr           = in_isr_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: entry, priority, return, masked pending, reset abort, re-rise on ack.
module tb_int_ctrl;
   logic        clk = 1'b0;
   logic        clr_n;
   logic [3:0]  irq;
   logic        int_en;
   logic        mret;
   logic [31:0] resume_pc;
   logic        int_set_pl_pause;
   logic        int_flag;
   logic [31:0] int_pc;
   logic [3:0]  irq_ack;
   logic [3:0]  int_cause;
   logic [31:0] epc;
   logic        in_isr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   int_ctrl #(.NUM_IRQ(4), .VEC_BASE(32'h0000_0100), .PAUSE_CYCLES(2)) dut (
      .clk(clk), .clr_n(clr_n), .irq(irq), .int_en(int_en), .mret(mret),
      .resume_pc(resume_pc), .int_set_pl_pause(int_set_pl_pause), .int_flag(int_flag),
      .int_pc(int_pc), .irq_ack(irq_ack), .int_cause(int_cause), .epc(epc), .in_isr(in_isr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered on the first observed PAUSE cycle; ends on the first ISR cycle.
   task automatic enter_seq(input string tag, input logic [3:0] c, input logic [31:0] pc_exp,
                            input logic [3:0] ack_exp, input logic [31:0] epc_exp,
                            input logic [3:0] irq_enter);
      check({tag, " pause1"}, 32'(int_set_pl_pause), 32'd1);
      check({tag, " cause"}, 32'(int_cause), 32'(c));
      step();
      check({tag, " pause2"}, 32'(int_set_pl_pause), 32'd1);
      check({tag, " noflag"}, 32'(int_flag), 32'd0);
      step();
      check({tag, " flag"}, 32'(int_flag), 32'd1);
      check({tag, " nopause"}, 32'(int_set_pl_pause), 32'd0);
      check({tag, " pc"}, int_pc, pc_exp);
      check({tag, " ack"}, 32'(irq_ack), 32'(ack_exp));
      check({tag, " epc"}, epc, epc_exp);
      irq = irq_enter;
      step();
      check({tag, " in_isr"}, 32'(in_isr), 32'd1);
      check({tag, " flagoff"}, 32'(int_flag), 32'd0);
      check({tag, " ackoff"}, 32'(irq_ack), 32'd0);
   endtask

   // Entered on an ISR cycle; ends on the IDLE cycle after RETURN.
   task automatic return_seq(input string tag, input logic [31:0] epc_exp);
      mret = 1'b1;
      step();
      mret = 1'b0;
      check({tag, " rpause1"}, 32'(int_set_pl_pause), 32'd1);
      check({tag, " rpause_isr"}, 32'(in_isr), 32'd1);
      step();
      check({tag, " rpause2"}, 32'(int_set_pl_pause), 32'd1);
      step();
      check({tag, " rflag"}, 32'(int_flag), 32'd1);
      check({tag, " rpc"}, int_pc, epc_exp);
      check({tag, " r_in_isr"}, 32'(in_isr), 32'd0);
      check({tag, " rnopause"}, 32'(int_set_pl_pause), 32'd0);
      step();
      check({tag, " idle_flag"}, 32'(int_flag), 32'd0);
      check({tag, " idle_isr"}, 32'(in_isr), 32'd0);
   endtask

   initial begin
      clr_n = 1'b0; irq = 4'b0000; int_en = 1'b1; mret = 1'b0; resume_pc = 32'h0;
      #12;
      check("rst pause", 32'(int_set_pl_pause), 32'd0);
      check("rst flag", 32'(int_flag), 32'd0);
      check("rst pc", int_pc, 32'd0);
      check("rst epc", epc, 32'd0);
      check("rst isr", 32'(in_isr), 32'd0);
      step();
      clr_n = 1'b1;
      step();
      check("idle pause", 32'(int_set_pl_pause), 32'd0);

      // Single IRQ entry, then mret return; epc must not follow resume_pc after entry.
      irq = 4'b0100; resume_pc = 32'h40;
      step();
      check("t1 pending_nopause", 32'(int_set_pl_pause), 32'd0);
      step();
      enter_seq("t1", 4'd2, 32'h108, 4'b0100, 32'h40, 4'b0000);
      resume_pc = 32'h999;
      return_seq("t3", 32'h40);
      step();
      check("t3 stay_idle", 32'(int_set_pl_pause), 32'd0);
      check("t3 epc_held", epc, 32'h40);

      // Simultaneous irq[3] and irq[1]: lower index first, then the other after return.
      irq = 4'b1010; resume_pc = 32'h80;
      step();
      step();
      enter_seq("t2a", 4'd1, 32'h104, 4'b0010, 32'h80, 4'b1010);
      resume_pc = 32'hC0;
      return_seq("t2a_ret", 32'h80);
      step();
      enter_seq("t2b", 4'd3, 32'h10C, 4'b1000, 32'hC0, 4'b0000);
      return_seq("t2b_ret", 32'hC0);

      // Masked IRQ stays pending; int_en drop during PAUSE does not cancel; re-rise on ack.
      int_en = 1'b0; irq = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4 masked", 32'(int_set_pl_pause), 32'd0);
      end
      irq = 4'b0000; int_en = 1'b1; resume_pc = 32'h200;
      step();
      int_en = 1'b0;
      enter_seq("t4", 4'd0, 32'h100, 4'b0001, 32'h200, 4'b0001);
      int_en = 1'b1; resume_pc = 32'h300;
      return_seq("t4_ret", 32'h200);
      step();
      enter_seq("t6", 4'd0, 32'h100, 4'b0001, 32'h300, 4'b0001);
      return_seq("t6_ret", 32'h300);
      step();
      check("t6 no_third", 32'(int_set_pl_pause), 32'd0);

      // Reset during PAUSE clears outputs at once and drops pending.
      irq = 4'b0101;
      step();
      step();
      check("t5 pause", 32'(int_set_pl_pause), 32'd1);
      check("t5 cause", 32'(int_cause), 32'd2);
      #2 clr_n = 1'b0;
      #1;
      check("t5 rst_pause", 32'(int_set_pl_pause), 32'd0);
      check("t5 rst_cause", 32'(int_cause), 32'd0);
      check("t5 rst_epc", epc, 32'd0);
      irq = 4'b0000;
      step();
      clr_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t5 no_pause", 32'(int_set_pl_pause), 32'd0);
         check("t5 no_flag", 32'(int_flag), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
